uart_tx_cfg: RTL and testbench
==============================

# uart_tx_cfg

Runtime-configurable UART transmit unit: a write-side FIFO feeding a frame serializer with an internal baud divider, all on one clock. It generalises the team's fixed 8E1 transmit path to any data width, none/even/odd parity, one or two stop bits, and back-to-back frames with no idle gap. It sits between the host write interface and the `tx` pin, beside the receive unit.

## Interface
- `DATA_WIDTH`, 8: data bits per frame, LSB first; legal 5..9.
- `FIFO_DEPTH`, 8: FIFO entries; power of 2, at least 2.
- `DIV_WIDTH`, 16: width of `baud_div`.
- `clk` in 1: single clock for the whole block.
- `rst` in 1: asynchronous, active-high reset.
- `baud_div` in DIV_WIDTH: bit period is `baud_div`+1 `clk` cycles.
- `parity_mode` in 2: 00 none, 01 even, 10 odd, 11 none.
- `stop_two` in 1: 1 selects two stop bits, 0 selects one.
- `tx_en` in 1: permits a new frame to start.
- `wen` in 1: FIFO write strobe.
- `wr_data` in DATA_WIDTH: FIFO write data.
- `tx` out 1: serial line; idles high.
- `tx_busy` out 1: a frame is in progress.
- `tx_done` out 1: one-cycle pulse at the end of each frame.
- `tx_empty`, `tx_full` out 1: FIFO status, registered.
- `tx_count` out $clog2(FIFO_DEPTH)+1: FIFO occupancy, 0..FIFO_DEPTH.
- `tx_overflow` out 1: one-cycle pulse when a write is rejected.

## Operation
- FIFO:
  - A write is accepted when `wen` is 1 and `tx_full` is 0.
  - A write with `tx_full` at 1 is dropped and pulses `tx_overflow`. This holds even if a pop occurs in the same cycle.
  - A pop happens only on a frame start and is never attempted when empty.
  - Read and write pointers are $clog2(FIFO_DEPTH)+1 bits wide and wrap naturally. Full means the pointer MSBs differ and the rest are equal.
- FSM states are IDLE, START, DATA, PARITY, STOP.
- Frame start:
  - In IDLE, a frame starts when `tx_en` is 1 and `tx_empty` is 0.
  - On a start, the FIFO head is popped into the shift register.
  - `baud_div`, `parity_mode` and `stop_two` are latched at the start and held for the whole frame. Config changes mid-frame affect only later frames.
- Bit sequence:
  - START drives `tx`=0 for one bit period.
  - DATA shifts out DATA_WIDTH bits, LSB first, using a bit counter.
  - PARITY is present only for modes 01 and 10. Even parity is the XOR of the data bits; odd parity is its inverse. The parity bit is computed from the popped word at load.
  - STOP drives `tx`=1 for 1 or 2 bit periods.
- Baud counter:
  - Reloads to 0 at every bit boundary.
  - A bit ends when the count equals the latched `baud_div`.
  - `baud_div`=0 gives 1 cycle per bit.
- End of frame:
  - `tx_done` pulses in the last cycle of the final stop bit.
  - In that same cycle, if `tx_en` is 1 and the FIFO is not empty, the FSM goes directly to START and pops. There is no idle bit between frames.
  - Otherwise the FSM returns to IDLE.
- Clearing `tx_en` mid-frame lets the current frame complete; no new frame starts.
- Reset, asynchronous and possibly mid-frame:
  - State goes to IDLE and the FIFO is flushed.
  - `tx` goes to 1, `tx_busy`, `tx_done` and `tx_overflow` go to 0, `tx_empty` goes to 1, `tx_full` goes to 0, `tx_count` goes to 0.

## Timing
- `tx` is driven from a register, so it is glitch-free.
- Write to empty FIFO:
  - `wen` sampled at edge N.
  - `tx_empty`=0 and `tx_count`=1 after edge N.
  - With `tx_en` at 1, the FSM enters START at edge N+1 and `tx` falls after edge N+1.
- Frame length is (1 + DATA_WIDTH + P + S) × (`baud_div`+1) cycles, where P is 0 or 1 and S is 1 or 2.
- `tx_busy` is 1 from the START entry edge to the return-to-IDLE edge. It stays 1 across back-to-back frames.
- `tx_count` and flags update on the edge after a push or pop. A simultaneous push and pop leaves the count unchanged.

## Test plan
- **8N1, single write:**
  - Setup: DATA_WIDTH=8, `baud_div`=3, mode 00, `stop_two`=0; write 0xA5.
  - Required: `tx` shows 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit; one `tx_done` pulse 40 cycles after the start edge; `tx_empty` returns to 1.
- **Parity modes:**
  - 0x07 with even parity gives parity bit 1; with odd, 0.
  - 0x00 with even parity gives parity bit 0.
  - Frame length is 44 cycles at `baud_div`=3.
- **Two stop bits, back-to-back:**
  - Write 0x11, 0x22, 0x33 with `tx_en` held at 1.
  - Required: three frames, each ending with 2 high bits; no extra idle bit between frames; `tx_busy` continuously 1; three `tx_done` pulses.
- **FIFO full and overflow:**
  - With `tx_en`=0, write 9 words.
  - Required: `tx_full`=1 and `tx_count`=8 after the 8th write; the 9th write pulses `tx_overflow` and is dropped.
  - Then set `tx_en`=1: the first 8 words are transmitted in order.
- **Mid-frame events:**
  - Change `parity_mode` and `baud_div` mid-frame: the current frame is unchanged and the next frame uses the new config.
  - Drop `tx_en` mid-frame: the frame completes, then the FSM goes to IDLE with `tx`=1.
- **Reset mid-frame:**
  - Assert `rst` during DATA.
  - Required: `tx`=1, `tx_busy`=0, `tx_empty`=1, `tx_count`=0 immediately, without waiting for a clock edge.
  - After release, a new write transmits correctly.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter, write FIFO feeding a frame serializer with baud divider
module uart_tx_cfg #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [DIV_WIDTH-1:0]        i_baud_div,
   input  logic [1:0]                  i_parity_mode,
   input  logic                        i_stop_two,
   input  logic                        i_tx_en,
   input  logic                        i_wen,
   input  logic [DATA_WIDTH-1:0]       i_wr_data,
   output logic                        o_tx,
   output logic                        o_tx_busy,
   output logic                        o_tx_done,
   output logic                        o_tx_empty,
   output logic                        o_tx_full,
   output logic [$clog2(FIFO_DEPTH):0] o_tx_count,
   output logic                        o_tx_overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(DATA_WIDTH + 1);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [AW:0]           r_wptr, r_rptr, r_count;
   logic                  r_empty, r_full, r_ovf;
   state_t                r_state, w_state_nxt;
   logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt, w_head;
   logic                  r_par, w_par_nxt;
   logic [DIV_WIDTH-1:0]  r_div, w_div_nxt, r_baud, w_baud_nxt;
   logic [1:0]            r_pmode, w_pmode_nxt;
   logic                  r_stop2, w_stop2_nxt;
   logic [BW-1:0]         r_bit, w_bit_nxt;
   logic                  r_tx, w_tx_nxt;
   logic                  w_push, w_pop, w_tick, w_done, w_has_par;
   logic [AW:0]           w_wptr_nxt, w_rptr_nxt;

   assign w_push     = i_wen & ~r_full;
   assign w_wptr_nxt = r_wptr + (AW+1)'(w_push);
   assign w_rptr_nxt = r_rptr + (AW+1)'(w_pop);
   assign w_head     = r_mem[r_rptr[AW-1:0]];
   assign w_tick     = (r_baud == r_div);
   assign w_has_par  = (r_pmode == 2'b01) || (r_pmode == 2'b10);

   assign o_tx          = r_tx;
   assign o_tx_busy     = (r_state != IDLE);
   assign o_tx_done     = w_done;
   assign o_tx_empty    = r_empty;
   assign o_tx_full     = r_full;
   assign o_tx_count    = r_count;
   assign o_tx_overflow = r_ovf;

   // FIFO storage; contents need no reset since the pointers define validity
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wr_data;
   end

   // FIFO pointers and registered status flags computed from next-state pointers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_empty <= 1'b1;
         r_full  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_wptr  <= w_wptr_nxt;
         r_rptr  <= w_rptr_nxt;
         r_count <= w_wptr_nxt - w_rptr_nxt;
         r_empty <= (w_wptr_nxt == w_rptr_nxt);
         r_full  <= (w_wptr_nxt[AW] != w_rptr_nxt[AW]) && (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]);
         r_ovf   <= i_wen & r_full;
      end
   end

   // Serializer registers, including the registered tx pin
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_div   <= '0;
         r_pmode <= 2'b00;
         r_stop2 <= 1'b0;
         r_baud  <= '0;
         r_bit   <= '0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_shift <= w_shift_nxt;
         r_par   <= w_par_nxt;
         r_div   <= w_div_nxt;
         r_pmode <= w_pmode_nxt;
         r_stop2 <= w_stop2_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_tx    <= w_tx_nxt;
      end
   end

   // Frame sequencing; a start (from IDLE or the final stop cycle) pops the FIFO and latches config
   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_par_nxt   = r_par;
      w_div_nxt   = r_div;
      w_pmode_nxt = r_pmode;
      w_stop2_nxt = r_stop2;
      w_baud_nxt  = w_tick ? '0 : r_baud + 1'b1;
      w_bit_nxt   = r_bit;
      w_done      = 1'b0;
      w_pop       = 1'b0;
      case (r_state)
         IDLE: begin
            w_baud_nxt = '0;
            w_pop      = i_tx_en & ~r_empty;
         end
         START: if (w_tick) w_state_nxt = DATA;
         DATA: if (w_tick) begin
            w_shift_nxt = r_shift >> 1;
            w_bit_nxt   = r_bit + 1'b1;
            if (r_bit == BW'(DATA_WIDTH - 1)) begin
               w_bit_nxt   = '0;
               w_state_nxt = w_has_par ? PARITY : STOP;
            end
         end
         PARITY: if (w_tick) w_state_nxt = STOP;
         STOP: if (w_tick) begin
            w_bit_nxt = r_bit + 1'b1;
            if (r_bit == BW'(r_stop2)) begin
               w_done      = 1'b1;
               w_bit_nxt   = '0;
               w_state_nxt = IDLE;
               w_pop       = i_tx_en & ~r_empty;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      if (w_pop) begin
         w_state_nxt = START;
         w_baud_nxt  = '0;
         w_bit_nxt   = '0;
         w_shift_nxt = w_head;
         w_par_nxt   = (^w_head) ^ (i_parity_mode == 2'b10);
         w_div_nxt   = i_baud_div;
         w_pmode_nxt = i_parity_mode;
         w_stop2_nxt = i_stop_two;
      end
      w_tx_nxt = (w_state_nxt == START)  ? 1'b0 :
                 (w_state_nxt == DATA)   ? w_shift_nxt[0] :
                 (w_state_nxt == PARITY) ? w_par_nxt : 1'b1;
   end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: scoreboard bench; stimulus queues expected frames, a line monitor decodes and compares
module tb_uart_tx_cfg;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] baud_div = 16'd3;
   logic [1:0]  parity_mode = 2'b00;
   logic        stop_two = 1'b0;
   logic        tx_en = 1'b0;
   logic        wen = 1'b0;
   logic [7:0]  wr_data = 8'h00;
   logic        tx, tx_busy, tx_done, tx_empty, tx_full, tx_overflow;
   logic [3:0]  tx_count;

   typedef struct {
      logic [12:0] bits;
      int          len;
      int          div;
      bit          chain;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   done_cnt = 0;
   bit   in_frame = 0;

   uart_tx_cfg #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .DIV_WIDTH(16)) dut (
      .i_clk(clk), .i_rst(rst), .i_baud_div(baud_div), .i_parity_mode(parity_mode),
      .i_stop_two(stop_two), .i_tx_en(tx_en), .i_wen(wen), .i_wr_data(wr_data),
      .o_tx(tx), .o_tx_busy(tx_busy), .o_tx_done(tx_done), .o_tx_empty(tx_empty),
      .o_tx_full(tx_full), .o_tx_count(tx_count), .o_tx_overflow(tx_overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (tx_done === 1'b1) done_cnt++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] d, input logic [1:0] pm, input bit st2,
                               input int div, input bit chain);
      exp_t e;
      int n;
      e.bits = '1;
      e.bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) e.bits[1+i] = d[i];
      n = 9;
      if (pm == 2'b01 || pm == 2'b10) begin
         e.bits[9] = (^d) ^ (pm == 2'b10);
         n = 10;
      end
      e.len = n + 1 + int'(st2);
      e.div = div;
      e.chain = chain;
      return e;
   endfunction

   function automatic exp_t hand(input logic [12:0] b, input int len, input int div, input bit chain);
      exp_t e;
      e.bits = b | ~((13'd1 << len) - 13'd1);
      e.len = len;
      e.div = div;
      e.chain = chain;
      return e;
   endfunction

   task automatic write(input logic [7:0] d);
      @(negedge clk);
      wen = 1'b1;
      wr_data = d;
      @(negedge clk);
      wen = 1'b0;
   endtask

   task automatic drain(input int max);
      int k;
      for (k = 0; k < max; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !in_frame && tx_busy === 1'b0) break;
      end
      if (k == max) chk("drain_timeout", 32'(exp_q.size()), 0);
   endtask

   // Line monitor: decodes frames at mid-bit, checks bits, done position, busy and back-to-back gaps
   initial begin
      exp_t e;
      logic [12:0] got;
      bit want_start, aborted, ok_busy;
      int per, done_at, done_n;
      want_start = 0;
      forever begin
         @(negedge clk);
         if (rst === 1'b1) want_start = 0;
         else begin
            if (want_start) begin
               chk("b2b_no_gap", 32'(tx), 0);
               want_start = 0;
            end
            if (tx === 1'b0) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_frame", 1, 0);
                  for (int k = 0; k < 2000 && tx === 1'b0; k++) @(negedge clk);
               end else begin
                  e = exp_q.pop_front();
                  in_frame = 1;
                  got = '1;
                  ok_busy = 1;
                  done_at = -1;
                  done_n = 0;
                  aborted = 0;
                  per = e.div + 1;
                  for (int c = 0; c < e.len * per; c++) begin
                     if (c > 0) @(negedge clk);
                     if (rst === 1'b1) begin
                        aborted = 1;
                        break;
                     end
                     if (c % per == e.div / 2) got[c/per] = tx;
                     if (tx_busy !== 1'b1) ok_busy = 0;
                     if (tx_done === 1'b1) begin
                        done_n++;
                        done_at = c;
                     end
                  end
                  in_frame = 0;
                  if (!aborted) begin
                     chk("frame_bits", 32'(got), 32'(e.bits));
                     chk("tx_done_pos", done_at, e.len * per - 1);
                     chk("tx_done_once", done_n, 1);
                     chk("busy_in_frame", 32'(ok_busy), 1);
                     want_start = e.chain;
                  end
               end
            end
         end
      end
   end

   // Directed stimulus
   initial begin
      int d0;
      repeat (2) @(negedge clk);
      chk("rst_tx", 32'(tx), 1);
      chk("rst_busy", 32'(tx_busy), 0);
      chk("rst_done", 32'(tx_done), 0);
      chk("rst_ovf", 32'(tx_overflow), 0);
      chk("rst_empty", 32'(tx_empty), 1);
      chk("rst_full", 32'(tx_full), 0);
      chk("rst_count", 32'(tx_count), 0);
      rst = 1'b0;
      @(negedge clk);

      // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
      tx_en = 1'b1;
      d0 = done_cnt;
      exp_q.push_back(hand(13'h34A, 10, 3, 0));
      write(8'hA5);
      chk("wr_empty", 32'(tx_empty), 0);
      chk("wr_count", 32'(tx_count), 1);
      chk("wr_tx_idle", 32'(tx), 1);
      @(negedge clk);
      chk("start_tx_low", 32'(tx), 0);
      chk("start_busy", 32'(tx_busy), 1);
      chk("start_popped", 32'(tx_count), 0);
      drain(200);
      chk("a5_empty", 32'(tx_empty), 1);
      chk("a5_done_pulses", 32'(done_cnt - d0), 1);

      // parity: 0x07 even -> 1, odd -> 0; 0x00 even -> 0; 44 cycles per frame
      parity_mode = 2'b01;
      exp_q.push_back(hand(13'h60E, 11, 3, 0));
      write(8'h07);
      drain(200);
      parity_mode = 2'b10;
      exp_q.push_back(hand(13'h40E, 11, 3, 0));
      write(8'h07);
      drain(200);
      parity_mode = 2'b01;
      exp_q.push_back(hand(13'h400, 11, 3, 0));
      write(8'h00);
      drain(200);

      // two stop bits, back-to-back
      parity_mode = 2'b00;
      stop_two = 1'b1;
      d0 = done_cnt;
      exp_q.push_back(mk(8'h11, 2'b00, 1, 3, 1));
      exp_q.push_back(mk(8'h22, 2'b00, 1, 3, 1));
      exp_q.push_back(mk(8'h33, 2'b00, 1, 3, 0));
      write(8'h11);
      write(8'h22);
      write(8'h33);
      drain(600);
      chk("b2b_done_pulses", 32'(done_cnt - d0), 3);

      // FIFO full and overflow
      stop_two = 1'b0;
      tx_en = 1'b0;
      for (int i = 0; i < 8; i++) write(8'h40 + 8'(i));
      chk("full_flag", 32'(tx_full), 1);
      chk("full_count", 32'(tx_count), 8);
      chk("no_ovf_yet", 32'(tx_overflow), 0);
      write(8'hEE);
      chk("ovf_pulse", 32'(tx_overflow), 1);
      chk("ovf_count", 32'(tx_count), 8);
      @(negedge clk);
      chk("ovf_one_cycle", 32'(tx_overflow), 0);
      d0 = done_cnt;
      for (int i = 0; i < 8; i++) exp_q.push_back(mk(8'h40 + 8'(i), 2'b00, 0, 3, i != 7));
      tx_en = 1'b1;
      drain(2000);
      chk("fifo_done_pulses", 32'(done_cnt - d0), 8);
      chk("fifo_drained", 32'(tx_empty), 1);

      // config change mid-frame takes effect on the next frame only
      d0 = done_cnt;
      exp_q.push_back(mk(8'h3C, 2'b00, 0, 3, 1));
      exp_q.push_back(mk(8'h96, 2'b01, 0, 1, 0));
      write(8'h3C);
      write(8'h96);
      repeat (8) @(negedge clk);
      parity_mode = 2'b01;
      baud_div = 16'd1;
      drain(400);
      chk("cfg_done_pulses", 32'(done_cnt - d0), 2);
      parity_mode = 2'b00;
      baud_div = 16'd3;

      // drop tx_en mid-frame
      exp_q.push_back(mk(8'hA1, 2'b00, 0, 3, 0));
      write(8'hA1);
      write(8'hB2);
      repeat (10) @(negedge clk);
      tx_en = 1'b0;
      drain(300);
      repeat (20) @(negedge clk);
      chk("en_off_tx", 32'(tx), 1);
      chk("en_off_busy", 32'(tx_busy), 0);
      chk("en_off_count", 32'(tx_count), 1);
      exp_q.push_back(mk(8'hB2, 2'b00, 0, 3, 0));
      tx_en = 1'b1;
      drain(300);

      // asynchronous reset during DATA
      exp_q.push_back(mk(8'h5A, 2'b00, 0, 3, 0));
      write(8'h5A);
      write(8'h6B);
      repeat (15) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_tx", 32'(tx), 1);
      chk("arst_busy", 32'(tx_busy), 0);
      chk("arst_empty", 32'(tx_empty), 1);
      chk("arst_count", 32'(tx_count), 0);
      chk("arst_full", 32'(tx_full), 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      d0 = done_cnt;
      exp_q.push_back(mk(8'hC3, 2'b00, 0, 3, 0));
      write(8'hC3);
      drain(200);
      chk("post_rst_done", 32'(done_cnt - d0), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
